// File: rtl/disp_scheduler.sv
// disp_scheduler
//   Round-robin arbiter with minimum dwell for the shared 8-digit
//   seven-segment display. It forwards the owner's digits and per-digit modes
//   to the scan FSM and generates the scan clock-enable pulse.
//
//   Optional feature: define DISP_SCHED_PREEMPT_EN to make requester 0 an
//   alarm channel. A rising req[0] then preempts any other owner.
//
// Parameters
//   SCAN_DIV     clock cycles per scan_tick pulse (>= 2)
//   DWELL_TICKS  minimum ownership in scan_tick pulses (0 allowed)
//   BLANK_MODE   per-digit mode code that blanks a digit
//
// Ports
//   clock       in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   req         in   [3:0]   per-requester request level
//   req_value   in   [127:0] requester i digits at [32i+31:32i]
//   req_mode    in   [95:0]  requester i modes at [24i+23:24i]
//   grant       out  [3:0]   one-hot owner, or zero
//   disp_value  out  [31:0]  owner's digits, 0 when no owner
//   disp_mode   out  [23:0]  owner's modes, all BLANK_MODE when no owner
//   scan_tick   out          one-cycle pulse every SCAN_DIV cycles
//   busy        out          registered |grant
module disp_scheduler #(
    parameter int unsigned SCAN_DIV    = 100000,
    parameter int unsigned DWELL_TICKS = 1024,
    parameter logic [2:0]  BLANK_MODE  = 3'b111
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [3:0]   req,
    input  logic [127:0] req_value,
    input  logic [95:0]  req_mode,
    output logic [3:0]   grant,
    output logic [31:0]  disp_value,
    output logic [23:0]  disp_mode,
    output logic         scan_tick,
    output logic         busy
);

    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam int unsigned DW = (DWELL_TICKS > 0) ? $clog2(DWELL_TICKS + 1) : 1;
    localparam logic [CW-1:0] DIV_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_TICKS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_OPEN
    } state_t;

    // A zero dwell means a fresh owner is immediately open to handover.
    localparam state_t S_ENTER = (DWELL_TICKS == 0) ? S_OPEN : S_HOLD;

    state_t        state, state_n;
    logic [1:0]    owner, owner_n;
    logic [1:0]    last_owner, last_n;
    logic [DW-1:0] dwell, dwell_n;
    logic [CW-1:0] div_cnt;
    logic [3:0]    cand;
    logic          pick_ok;
    logic [1:0]    pick_idx;
    logic          rearb;
    logic [31:0]   sel_value;
    logic [23:0]   sel_mode;
`ifdef DISP_SCHED_PREEMPT_EN
    logic          req0_q;
`endif

    // Returns {found, index} of the first set bit of cand, searching
    // base+1, base+2, base+3, base (mod 4).
    function automatic logic [2:0] rr_pick(input logic [3:0] c, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int unsigned k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (c[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // Free-running scan divider.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt   <= '0;
            scan_tick <= 1'b0;
        end else begin
            scan_tick <= (div_cnt == DIV_LAST);
            div_cnt   <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last_owner;
        dwell_n = dwell;
        rearb   = 1'b0;
        // Masking the current owner out makes it the last candidate on a
        // handover, even when last_owner still points at a preempted owner.
        cand    = req & ~grant;
        {pick_ok, pick_idx} = rr_pick(cand, last_owner);

        case (state)
            S_IDLE: rearb = |req;
            S_HOLD: begin
                // An owner drop takes priority over any tick in the same cycle.
                if (!req[owner]) begin
                    rearb = 1'b1;
                end else if (scan_tick) begin
                    if (dwell <= DW'(1)) begin
                        if (|cand) begin
                            rearb = 1'b1;
                        end else begin
                            state_n = S_OPEN;
                            dwell_n = '0;
                        end
                    end else begin
                        dwell_n = dwell - 1'b1;
                    end
                end
            end
            S_OPEN: rearb = !req[owner] || (|cand);
            default: state_n = S_IDLE;
        endcase

        if (rearb) begin
            if (pick_ok) begin
                owner_n = pick_idx;
                last_n  = pick_idx;
                dwell_n = DWELL_LOAD;
                state_n = S_ENTER;
            end else begin
                state_n = S_IDLE;
                dwell_n = '0;
            end
        end

`ifdef DISP_SCHED_PREEMPT_EN
        // last_owner keeps pointing at the preempted owner so round-robin
        // resumes after it once the alarm is released.
        if (state != S_IDLE && req[0] && !req0_q && owner != 2'd0) begin
            owner_n = 2'd0;
            last_n  = last_owner;
            dwell_n = DWELL_LOAD;
            state_n = S_ENTER;
        end
`endif
    end

    always_comb begin
        sel_value = '0;
        sel_mode  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (owner_n == 2'(i)) begin
                sel_value = req_value[32*i +: 32];
                sel_mode  = req_mode[24*i +: 24];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            owner      <= '0;
            last_owner <= 2'd3;
            dwell      <= '0;
            grant      <= '0;
            busy       <= 1'b0;
            disp_value <= '0;
            disp_mode  <= {8{BLANK_MODE}};
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_n;
            dwell      <= dwell_n;
            if (state_n != S_IDLE) begin
                grant      <= 4'b0001 << owner_n;
                busy       <= 1'b1;
                disp_value <= sel_value;
                disp_mode  <= sel_mode;
            end else begin
                grant      <= '0;
                busy       <= 1'b0;
                disp_value <= '0;
                disp_mode  <= {8{BLANK_MODE}};
            end
        end
    end

`ifdef DISP_SCHED_PREEMPT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) req0_q <= 1'b0;
        else          req0_q <= req[0];
    end
`endif

endmodule

// File: tb/tb_disp_scheduler.sv
// tb_disp_scheduler
//   Self-checking bench for disp_scheduler with SCAN_DIV=4, DWELL_TICKS=2.
//   A behavioural model (owner index, ticks served, round-robin pointer)
//   predicts every output each cycle. Directed scenarios add explicit
//   constant checks on the documented corner cases.
module tb_disp_scheduler;

    localparam int unsigned SCAN_DIV    = 4;
    localparam int unsigned DWELL_TICKS = 2;
    localparam logic [2:0]  BLANK_MODE  = 3'b111;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   req = '0;
    logic [127:0] req_value = '0;
    logic [95:0]  req_mode = '0;
    logic [3:0]   grant;
    logic [31:0]  disp_value;
    logic [23:0]  disp_mode;
    logic         scan_tick;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int          m_owner;
    int          m_last;
    int          m_ticks;
    int          m_cycle;
    logic        m_tick;
    logic        m_req0_prev;
    logic [3:0]  e_grant;
    logic        e_busy;
    logic [31:0] e_value;
    logic [23:0] e_mode;

    logic [61:0] obs;
    logic [61:0] exp_v;
    assign obs   = {grant, busy, scan_tick, disp_value, disp_mode};
    assign exp_v = {e_grant, e_busy, m_tick, e_value, e_mode};

    disp_scheduler #(
        .SCAN_DIV   (SCAN_DIV),
        .DWELL_TICKS(DWELL_TICKS),
        .BLANK_MODE (BLANK_MODE)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .req_value (req_value),
        .req_mode  (req_mode),
        .grant     (grant),
        .disp_value(disp_value),
        .disp_mode (disp_mode),
        .scan_tick (scan_tick),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    function automatic int pick(input logic [3:0] c, input int last);
        for (int k = 1; k <= 4; k++)
            if (c[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner     = -1;
        m_last      = 3;
        m_ticks     = 0;
        m_cycle     = 0;
        m_tick      = 1'b0;
        m_req0_prev = 1'b0;
        e_grant     = '0;
        e_busy      = 1'b0;
        e_value     = '0;
        e_mode      = {8{BLANK_MODE}};
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step();
        logic [3:0] others;
        bit done;
        bit preempt;
        preempt = 0;
`ifdef DISP_SCHED_PREEMPT_EN
        if (m_owner > 0 && req[0] && !m_req0_prev) begin
            m_owner = 0;
            m_ticks = 0;
            preempt = 1;
        end
`endif
        if (!preempt) begin
            if (m_owner < 0) begin
                if (req != 4'b0000) begin
                    m_owner = pick(req, m_last);
                    m_last  = m_owner;
                    m_ticks = 0;
                end
            end else begin
                others = req;
                others[m_owner] = 1'b0;
                done = (m_ticks + (m_tick ? 1 : 0)) >= int'(DWELL_TICKS);
                if (!req[m_owner] || (done && others != 4'b0000)) begin
                    if (others != 4'b0000) begin
                        m_owner = pick(others, m_last);
                        m_last  = m_owner;
                        m_ticks = 0;
                    end else begin
                        m_owner = -1;
                    end
                end else if (m_tick && m_ticks < int'(DWELL_TICKS)) begin
                    m_ticks++;
                end
            end
        end
        m_req0_prev = req[0];
        if (m_owner >= 0) begin
            e_grant = 4'b0001 << m_owner;
            e_busy  = 1'b1;
            e_value = req_value[m_owner*32 +: 32];
            e_mode  = req_mode[m_owner*24 +: 24];
        end else begin
            e_grant = '0;
            e_busy  = 1'b0;
            e_value = '0;
            e_mode  = {8{BLANK_MODE}};
        end
        m_cycle++;
        m_tick = (m_cycle % SCAN_DIV) == 0;
    endtask

    task automatic step();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        req = '0;
        req_value = '0;
        req_mode = '0;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", obs, exp_v);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_scan_tick();
        req = '0;
        for (int c = 1; c <= 12; c++) begin
            step();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL scan_idle cycle %0d: got %h expected %h", c, obs, exp_v);
            end
            n_checks++;
            if (scan_tick !== ((c % 4) == 0)) begin
                n_fail++;
                $display("FAIL scan_tick cycle %0d: got %b expected %b", c, scan_tick, (c % 4) == 0);
            end
        end
    endtask

    task automatic test_idle_grant();
        req_value = {$urandom(), 32'h1234_5678, $urandom(), $urandom()};
        req_mode  = {$urandom(), $urandom(), $urandom()};
        req = 4'b0100;
        step();
        n_checks++;
        if (grant !== 4'b0100 || disp_value !== 32'h1234_5678 || busy !== 1'b1 || obs !== exp_v) begin
            n_fail++;
            $display("FAIL idle_grant: got grant=%b value=%h busy=%b all=%h expected grant=0100 value=12345678 busy=1 all=%h",
                     grant, disp_value, busy, obs, exp_v);
        end
        req_value[95:64] = 32'hCAFE_0001;
        step();
        n_checks++;
        if (disp_value !== 32'hCAFE_0001 || obs !== exp_v) begin
            n_fail++;
            $display("FAIL value_follow: got value=%h all=%h expected value=cafe0001 all=%h", disp_value, obs, exp_v);
        end
        req = 4'b0000;
        step();
        n_checks++;
        if (grant !== 4'b0000 || disp_mode !== 24'hFFFFFF || obs !== exp_v) begin
            n_fail++;
            $display("FAIL idle_release: got grant=%b mode=%h all=%h expected grant=0000 mode=ffffff all=%h",
                     grant, disp_mode, obs, exp_v);
        end
    endtask

    // Owner is observed for ticks served; the handover must land exactly in
    // the cycle after the expected-th tick.
    task automatic dwell_watch(input string name, input logic [3:0] own, input logic [3:0] nxt);
        int  ticks;
        bit  moved;
        logic prev_tick;
        ticks = 0;
        moved = 0;
        for (int i = 0; i < 40 && !moved; i++) begin
            prev_tick = scan_tick;
            if (prev_tick) ticks++;
            step();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL %s_model: got %h expected %h", name, obs, exp_v);
            end
            if (grant === nxt) begin
                moved = 1;
                n_checks++;
                if (ticks != int'(DWELL_TICKS) || prev_tick !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_handover: got ticks=%0d tick_before=%b expected ticks=%0d tick_before=1",
                             name, ticks, prev_tick, DWELL_TICKS);
                end
            end else if (grant !== own) begin
                n_fail++;
                n_checks++;
                $display("FAIL %s_owner: got grant=%b expected %b", name, grant, own);
            end
        end
        n_checks++;
        if (!moved) begin
            n_fail++;
            $display("FAIL %s_timeout: got grant=%b expected %b", name, grant, nxt);
        end
    endtask

    task automatic test_dwell();
        req = 4'b0011;
        step();
        n_checks++;
        if (grant !== 4'b0001 || obs !== exp_v) begin
            n_fail++;
            $display("FAIL dwell_first: got grant=%b all=%h expected grant=0001 all=%h", grant, obs, exp_v);
        end
        dwell_watch("dwell", 4'b0001, 4'b0010);
    endtask

    task automatic test_round_robin();
        logic [3:0] prev;
        int hand;
        req = 4'b1111;
        prev = grant;
        hand = 0;
        for (int i = 0; i < 400 && hand < 20; i++) begin
            step();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rr_model: got %h expected %h", obs, exp_v);
            end
            if (grant !== prev) begin
                hand++;
                n_checks++;
                if (grant !== {prev[2:0], prev[3]}) begin
                    n_fail++;
                    $display("FAIL rr_order: got grant=%b expected %b", grant, {prev[2:0], prev[3]});
                end
                prev = grant;
            end
        end
        n_checks++;
        if (hand < 20) begin
            n_fail++;
            $display("FAIL rr_timeout: got %0d handovers expected 20", hand);
        end
    endtask

    task automatic test_drop_on_tick();
        bit done;
        req = 4'b0000;
        repeat (2) step();
        req = 4'b0010;
        step();
        n_checks++;
        if (grant !== 4'b0010 || obs !== exp_v) begin
            n_fail++;
            $display("FAIL drop_setup: got grant=%b all=%h expected grant=0010 all=%h", grant, obs, exp_v);
        end
        req = 4'b0110;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (scan_tick === 1'b1) begin
                req = 4'b0100;
                done = 1;
            end
            step();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL drop_model: got %h expected %h", obs, exp_v);
            end
        end
        n_checks++;
        if (!done || grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL drop_on_tick: got grant=%b expected 0100", grant);
        end
        req = 4'b0101;
        dwell_watch("drop_reload", 4'b0100, 4'b0001);
    endtask

    task automatic test_random();
        req = '0;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
            if ($urandom_range(0, 3) == 0)
                req_value = {$urandom(), $urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 5) == 0)
                req_mode = {$urandom(), $urandom(), $urandom()};
            step();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL random cycle %0d req=%b: got %h expected %h", i, req, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        req = '0;
        repeat (2) step();
        req = 4'b1000;
        step();
        step();
        n_checks++;
        if (grant !== 4'b1000 || obs !== exp_v) begin
            n_fail++;
            $display("FAIL mid_setup: got grant=%b all=%h expected grant=1000 all=%h", grant, obs, exp_v);
        end
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (grant !== 4'b0000 || disp_value !== 32'h0 || busy !== 1'b0 ||
            disp_mode !== {8{BLANK_MODE}} || scan_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got grant=%b value=%h busy=%b mode=%h tick=%b expected 0000/0/0/ffffff/0",
                     grant, disp_value, busy, disp_mode, scan_tick);
        end
        @(negedge clock);
        reset_n = 1'b1;
        step();
        n_checks++;
        if (grant !== 4'b1000 || obs !== exp_v) begin
            n_fail++;
            $display("FAIL after_reset: got grant=%b all=%h expected grant=1000 all=%h", grant, obs, exp_v);
        end
    endtask

`ifdef DISP_SCHED_PREEMPT_EN
    task automatic test_preempt();
        req = 4'b1001;
        step();
        n_checks++;
        if (grant !== 4'b0001 || obs !== exp_v) begin
            n_fail++;
            $display("FAIL preempt: got grant=%b all=%h expected grant=0001 all=%h", grant, obs, exp_v);
        end
        req = 4'b1000;
        step();
        n_checks++;
        if (grant !== 4'b1000 || obs !== exp_v) begin
            n_fail++;
            $display("FAIL preempt_release: got grant=%b all=%h expected grant=1000 all=%h", grant, obs, exp_v);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scan_tick();
        test_idle_grant();
        test_dwell();
        test_round_robin();
        test_drop_on_tick();
        test_random();
        test_reset_mid();
`ifdef DISP_SCHED_PREEMPT_EN
        test_preempt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_scheduler.md
# disp_scheduler

Arbitrates the shared 8-digit seven-segment display between four requesters and paces its digit scan. Each requester presents a 32-bit value (8 nibbles) and a 24-bit per-digit mode word (8 × 3 bits). A round-robin arbiter with a minimum dwell time picks the owner and drives the owner's data onto `disp_value`/`disp_mode`. The block also generates `scan_tick`, which is used as the clock enable of the digit-scan FSM.

## Interface
- `SCAN_DIV`, 100000: clock cycles per `scan_tick` pulse; legal range ≥ 2.
- `DWELL_TICKS`, 1024: minimum ownership, counted in `scan_tick` pulses; 0 is legal.
- `BLANK_MODE`, 3'b111: per-digit mode code that blanks a digit.
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  request; held high while requester i wants the display.
- `req_value`  in  128  requester i digits at [32i+31:32i].
- `req_mode`  in  96  requester i digit modes at [24i+23:24i].
- `grant`  out  4  one-hot owner, or all zero.
- `disp_value`  out  32  value to the scan FSM.
- `disp_mode`  out  24  mode word to the scan FSM.
- `scan_tick`  out  1  one-cycle pulse every `SCAN_DIV` cycles.
- `busy`  out  1  high while any grant is active.

## Operation
- Divider: counter runs 0..`SCAN_DIV`-1 and wraps. `scan_tick`=1 in the cycle after the counter equals `SCAN_DIV`-1. The divider runs free, independent of arbitration.
- The FSM has three states: IDLE, HOLD, OPEN.
- IDLE:
  - no `req` bit set → stay.
  - any `req` bit set → grant the winner, load the dwell counter with `DWELL_TICKS`, go to HOLD. If `DWELL_TICKS`=0, go to OPEN instead.
- HOLD:
  - Each `scan_tick` decrements the dwell counter.
  - Counter reaches 0 → go to OPEN.
  - Owner drops `req` → re-arbitrate on the same edge. The new owner enters HOLD, or the FSM returns to IDLE if no request is pending.
  - Other requesters are ignored while in HOLD.
- OPEN:
  - Owner keeps `req` and no other request is pending → stay.
  - Another request is pending, or the owner drops `req` → re-arbitrate and hand over on the same edge. The new owner enters HOLD; IDLE if none.
- Round-robin search:
  - Starts at (last_owner+1) mod 4.
  - last_owner resets to 3, so requester 0 wins first.
  - When handing over from OPEN while the owner still holds `req`, the current owner is checked last.
- Data path:
  - While a grant is held, `disp_value`/`disp_mode` register the owner's slices every cycle.
  - With no owner, they are 0 and {8{`BLANK_MODE`}}.
- `busy` = |`grant`, registered.

## Timing
- Reset values:
  - `grant`=0, `busy`=0, `scan_tick`=0.
  - `disp_value`=32'h0, `disp_mode`={8{`BLANK_MODE`}}.
  - divider=0, dwell=0, state IDLE, last_owner=3.
- Grant latency: `req` high in cycle n (IDLE) → `grant`, `busy` and matching `disp_value`/`disp_mode` valid in cycle n+1.
- A change in `req_value` of the owner appears on `disp_value` one cycle later.
- Handover never leaves `grant` zero for a cycle when another request is pending.
- Owner drop in the same cycle as `scan_tick`: the drop wins and the dwell decrement is discarded.
- All four requests high with the owner held: the owner rotates every `DWELL_TICKS` scan ticks (plus the tick-alignment remainder).
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously). Release is synchronous to the next `clock` edge.

## Configuration
- `DISP_SCHED_PREEMPT_EN`
  - Defined: requester 0 is an alarm channel. If `req`[0] rises while another requester owns the display (HOLD or OPEN), requester 0 is granted on the next edge, dwell is reloaded and the FSM enters HOLD. When the alarm is released, round-robin resumes after the preempted owner.
  - Undefined: requester 0 is an ordinary round-robin participant with no preemption.

## Test plan
- `SCAN_DIV`=4: after reset release, `scan_tick` pulses on cycles 4, 8, 12 and is high for exactly 1 cycle each.
- Idle grant: `req`=4'b0100, `req_value`[95:64]=32'h1234_5678 → next cycle `grant`=4'b0100, `disp_value`=32'h1234_5678, `busy`=1. Dropping `req` → next cycle `grant`=0, `disp_mode`=24'hFFFFFF.
- Dwell (`SCAN_DIV`=4, `DWELL_TICKS`=2):
  - `req`=4'b0011 → requester 0 is granted.
  - requester 1 is not granted before the 2nd `scan_tick` after the grant.
  - requester 1 is granted one cycle after the 2nd `scan_tick`.
- Round-robin fairness: `req`=4'b1111 held for 20 dwell periods → grant order 0,1,2,3,0,…; no requester skipped.
- Simultaneous owner drop and `scan_tick` in HOLD with `req`[2] pending → `grant`=4'b0100 next cycle, with dwell reloaded to `DWELL_TICKS`.
- Reset mid-HOLD: assert `reset_n`=0 → `grant`=0, `disp_value`=0 in the same cycle. With `DISP_SCHED_PREEMPT_EN`, `req`[0] rising during requester 3's HOLD → `grant`=4'b0001 next cycle.
